lcd_access_scheduler: RTL and testbench

Sequences and shares the single LCD_controller instance between two independent requesters (e.g. a PS2 character path and a status/command path). Runs the fixed LCD power-up sequence after reset, then arbitrates round-robin between requesters, drives the LCD_controller start/instruction/done handshake, and tracks the cursor (position 0–15, line 0/1). At end of line it inserts the line-change command automatically. Sits between the top-level FSM logic and LCD_controller; it replaces the per-design init/issue/change-line states.

---
 rtl/lcd_sched_pkg.sv | 36 +++
 rtl/lcd_access_scheduler_if.sv | 11 +
 rtl/lcd_rr_arbiter.sv | 33 +++
 rtl/lcd_access_scheduler.sv | 152 +++++++++++++++
 tb/tb_lcd_access_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for lcd_access_scheduler.
// Optional feature: define LCD_AUTO_WRAP_EN to insert the line-change
// command automatically when a data write fills the last column.
package lcd_sched_pkg;

   // Scheduler FSM states; the wrap states only exist when auto-wrap is built in.
   typedef enum logic [2:0] {
      S_INIT_ISSUE,
      S_INIT_WAIT,
      S_IDLE,
      S_ISSUE,
      S_WAIT,
`ifdef LCD_AUTO_WRAP_EN
      S_WRAP_ISSUE,
      S_WRAP_WAIT,
`endif
      S_ACK
   } state_t;

   // LCD power-up sequence, entry 0 is issued first:
   // function set, display on, clear, entry mode, home.
   localparam int                            LCD_INIT_LEN = 5;
   localparam logic [LCD_INIT_LEN-1:0][8:0] LCD_INIT_SEQ = {
      9'h080, 9'h006, 9'h001, 9'h00C, 9'h038
   };

   localparam logic [8:0] LCD_CMD_CLEAR    = 9'h001;
   // Bits [8:7] of a set-DDRAM-address command.
   localparam logic [1:0] LCD_CMD_SET_ADDR = 2'b01;

   // Command that moves the cursor to column 0 of the other line.
   function automatic logic [8:0] lcd_line_cmd(input logic line);
      return {LCD_CMD_SET_ADDR, ~line, 6'h00};
   endfunction

endpackage

// File: rtl/lcd_access_scheduler_if.sv
// Requester-side bus of lcd_access_scheduler: two request/instruction
// pairs in, per-requester acknowledge and the ready flag out.
interface lcd_access_scheduler_if;
   logic [1:0]      Req_i;
   logic [1:0][8:0] Instr_i;
   logic [1:0]      Ack_o;
   logic            Ready_o;

   modport master (output Req_i, Instr_i, input Ack_o, Ready_o);
   modport slave  (input Req_i, Instr_i, output Ack_o, Ready_o);
endinterface

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter. Grant is combinational from the requests and
// a registered priority pointer; the pointer moves past whoever was granted.
module lcd_rr_arbiter (
   input  logic       Clock_50,
   input  logic       Resetn,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic [1:0] gnt
);

   logic ptr;

   // Pick the pointed-to requester first, otherwise the other one.
   always_comb begin
      // NOTE: default assignment first so no path leaves gnt unassigned (no latch).
      gnt = 2'b00;
      if (ptr) begin
         if (req[1])      gnt = 2'b10;
         else if (req[0]) gnt = 2'b01;
      end else begin
         if (req[0])      gnt = 2'b01;
         else if (req[1]) gnt = 2'b10;
      end
   end

   // Advance the pointer to the requester that did not win.
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      // NOTE: state registers use non-blocking assignments only.
      if (!Resetn)                ptr <= 1'b0;
      else if (grant_en && |gnt)  ptr <= gnt[0];
   end

endmodule

// File: rtl/lcd_access_scheduler.sv
// Shares one LCD_controller between two requesters: runs the power-up
// sequence, arbitrates round-robin, drives the start/done handshake and
// tracks the cursor. Define LCD_AUTO_WRAP_EN to insert the line-change
// command after a data write to the last column.
module lcd_access_scheduler
   import lcd_sched_pkg::*;
#(
   parameter int NUM_COLS = 16
) (
   input  logic                   Clock_50,
   input  logic                   Resetn,
   lcd_access_scheduler_if.slave  bus,
   output logic                   LCD_start,
   output logic [8:0]             LCD_instruction,
   input  logic                   LCD_done,
   output logic [3:0]             Cursor_pos_o,
   output logic                   Cursor_line_o
);

   localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);

   state_t     state;
   logic [2:0] init_idx;
   logic [8:0] instr_q;
   logic [1:0] gnt_q;
   logic [1:0] gnt;
   logic [1:0] ack_q;
   logic       ready_q;
   logic       grant_en;
   // Done is only meaningful once our own start pulse has dropped.
   logic       done_seen;

   assign grant_en    = (state == S_IDLE);
   assign done_seen   = LCD_done && !LCD_start;
   assign bus.Ack_o   = ack_q;
   assign bus.Ready_o = ready_q;

   lcd_rr_arbiter u_arb (
      .Clock_50 (Clock_50),
      .Resetn   (Resetn),
      .req      (bus.Req_i),
      .grant_en (grant_en),
      .gnt      (gnt)
   );

   // Scheduler FSM with registered LCD handshake, acknowledge and cursor outputs.
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         state           <= S_INIT_ISSUE;
         init_idx        <= 3'd0;
         instr_q         <= 9'd0;
         gnt_q           <= 2'b00;
         LCD_start       <= 1'b0;
         LCD_instruction <= 9'd0;
         ack_q           <= 2'b00;
         ready_q         <= 1'b0;
         Cursor_pos_o    <= 4'd0;
         Cursor_line_o   <= 1'b0;
      end else begin
         case (state)
            S_INIT_ISSUE: begin
               LCD_instruction <= LCD_INIT_SEQ[init_idx];
               LCD_start       <= 1'b1;
               state           <= S_INIT_WAIT;
            end

            S_INIT_WAIT: begin
               LCD_start <= 1'b0;
               if (done_seen) begin
                  if (init_idx == 3'(LCD_INIT_LEN - 1)) begin
                     init_idx      <= 3'd0;
                     Cursor_pos_o  <= 4'd0;
                     Cursor_line_o <= 1'b0;
                     ready_q       <= 1'b1;
                     state         <= S_IDLE;
                  end else begin
                     init_idx <= init_idx + 3'd1;
                     state    <= S_INIT_ISSUE;
                  end
               end
            end

            S_IDLE: begin
               if (|gnt) begin
                  gnt_q   <= gnt;
                  instr_q <= gnt[1] ? bus.Instr_i[1] : bus.Instr_i[0];
                  ready_q <= 1'b0;
                  state   <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               LCD_instruction <= instr_q;
               LCD_start       <= 1'b1;
               state           <= S_WAIT;
            end

            S_WAIT: begin
               LCD_start <= 1'b0;
               if (done_seen) begin
                  ack_q <= gnt_q;
                  state <= S_ACK;
                  if (instr_q[8]) begin
                     if (Cursor_pos_o == LAST_COL) begin
                        Cursor_pos_o <= 4'd0;
`ifdef LCD_AUTO_WRAP_EN
                        // Hold the acknowledge until the line change is done.
                        ack_q <= 2'b00;
                        state <= S_WRAP_ISSUE;
`endif
                     end else begin
                        Cursor_pos_o <= Cursor_pos_o + 4'd1;
                     end
                  end else if (instr_q[8:7] == LCD_CMD_SET_ADDR) begin
                     Cursor_line_o <= instr_q[6];
                     Cursor_pos_o  <= instr_q[3:0];
                  end else if (instr_q == LCD_CMD_CLEAR) begin
                     Cursor_pos_o  <= 4'd0;
                     Cursor_line_o <= 1'b0;
                  end
               end
            end

`ifdef LCD_AUTO_WRAP_EN
            S_WRAP_ISSUE: begin
               LCD_instruction <= lcd_line_cmd(Cursor_line_o);
               LCD_start       <= 1'b1;
               Cursor_line_o   <= ~Cursor_line_o;
               state           <= S_WRAP_WAIT;
            end

            S_WRAP_WAIT: begin
               LCD_start <= 1'b0;
               if (done_seen) begin
                  ack_q <= gnt_q;
                  state <= S_ACK;
               end
            end
`endif

            S_ACK: begin
               ack_q   <= 2'b00;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end

            default: state <= S_INIT_ISSUE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_access_scheduler.sv
// Directed bench for lcd_access_scheduler with a simple LCD_controller model
// that answers each start with a one-cycle done 20 cycles later.
module tb_lcd_access_scheduler;

   logic       Clock_50 = 1'b0;
   logic       Resetn   = 1'b0;
   logic       LCD_start;
   logic [8:0] LCD_instruction;
   logic       LCD_done = 1'b0;
   logic [3:0] Cursor_pos_o;
   logic       Cursor_line_o;

   int         n_checks   = 0;
   int         n_errors   = 0;
   int         lcd_cnt    = 0;
   int         ack_cycles = 0;
   logic [8:0] issued[$];

   lcd_access_scheduler_if bus ();

   lcd_access_scheduler #(.NUM_COLS(16)) dut (
      .Clock_50        (Clock_50),
      .Resetn          (Resetn),
      .bus             (bus),
      .LCD_start       (LCD_start),
      .LCD_instruction (LCD_instruction),
      .LCD_done        (LCD_done),
      .Cursor_pos_o    (Cursor_pos_o),
      .Cursor_line_o   (Cursor_line_o)
   );

   always #10 Clock_50 = ~Clock_50;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   // LCD_controller model plus instruction log and acknowledge-cycle counter.
   initial begin
      forever begin
         @(posedge Clock_50);
         #1;
         if (bus.Ack_o != 2'b00) ack_cycles++;
         if (!Resetn) begin
            lcd_cnt  = 0;
            LCD_done = 1'b0;
         end else if (LCD_done) begin
            LCD_done = 1'b0;
         end else if (lcd_cnt != 0) begin
            lcd_cnt--;
            if (lcd_cnt == 0) LCD_done = 1'b1;
         end else if (LCD_start) begin
            issued.push_back(LCD_instruction);
            lcd_cnt = 20;
         end
      end
   end

   // Hard stop in case a bounded wait is ever bypassed.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.Ready_o !== 1'b1 && n < 1000) begin
         @(negedge Clock_50);
         n++;
      end
      check(tag, 32'(bus.Ready_o), 32'd1);
   endtask

   task automatic wait_ack(output logic [1:0] ack);
      int n = 0;
      do begin
         @(negedge Clock_50);
         n++;
      end while (bus.Ack_o == 2'b00 && n < 400);
      ack = bus.Ack_o;
   endtask

   task automatic do_req(input int idx, input logic [8:0] instr, output logic [1:0] ack);
      bus.Instr_i[idx] = instr;
      bus.Req_i[idx]   = 1'b1;
      wait_ack(ack);
      bus.Req_i[idx]   = 1'b0;
   endtask

   task automatic check_init(input string tag);
      logic [8:0] exp_init [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
      check({tag, "_count"}, 32'(issued.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         check($sformatf("%s_%0d", tag, i),
               32'((i < issued.size()) ? issued[i] : 9'h1FF), 32'(exp_init[i]));
   endtask

   initial begin
      logic [1:0] a;
      int         n;
      int         acks0;
      int         iss0;

      bus.Req_i   = 2'b00;
      bus.Instr_i = '0;
      Resetn      = 1'b0;
      repeat (2) @(negedge Clock_50);

      // Reset values
      check("rst_start", 32'(LCD_start), 32'd0);
      check("rst_instr", 32'(LCD_instruction), 32'd0);
      check("rst_ack",   32'(bus.Ack_o), 32'd0);
      check("rst_ready", 32'(bus.Ready_o), 32'd0);
      check("rst_pos",   32'(Cursor_pos_o), 32'd0);
      check("rst_line",  32'(Cursor_line_o), 32'd0);

      // Power-up sequence
      Resetn = 1'b1;
      wait_ready("init_ready");
      check_init("init");
      check("init_pos",  32'(Cursor_pos_o), 32'd0);
      check("init_line", 32'(Cursor_line_o), 32'd0);

      // Grant and ack latency, other command leaves cursor alone (pointer ends at 0)
      bus.Instr_i[1] = 9'h006;
      bus.Req_i[1]   = 1'b1;
      @(negedge Clock_50);
      check("lat_start_lo", 32'(LCD_start), 32'd0);
      @(negedge Clock_50);
      check("lat_start_hi", 32'(LCD_start), 32'd1);
      check("lat_instr",    32'(LCD_instruction), 32'h006);
      n = 0;
      while (!LCD_done && n < 100) begin
         @(negedge Clock_50);
         n++;
      end
      check("lat_done_seen", 32'(LCD_done), 32'd1);
      @(negedge Clock_50);
      check("lat_ack", 32'(bus.Ack_o), 32'h2);
      bus.Req_i[1] = 1'b0;
      @(negedge Clock_50);
      check("lat_ack_drop", 32'(bus.Ack_o), 32'd0);
      check("lat_ready",    32'(bus.Ready_o), 32'd1);
      check("lat_pos",      32'(Cursor_pos_o), 32'd0);
      check("lat_line",     32'(Cursor_line_o), 32'd0);

      // Simultaneous requests: 0 first (set-address 0C5), then 1 (clear)
      bus.Instr_i[0] = 9'h0C5;
      bus.Instr_i[1] = 9'h001;
      bus.Req_i      = 2'b11;
      wait_ack(a);
      check("rr_ack0",  32'(a), 32'h1);
      check("rr_instr0", 32'(LCD_instruction), 32'h0C5);
      check("addr_pos",  32'(Cursor_pos_o), 32'd5);
      check("addr_line", 32'(Cursor_line_o), 32'd1);
      bus.Req_i[0] = 1'b0;
      wait_ack(a);
      bus.Req_i[1] = 1'b0;
      check("rr_ack1",   32'(a), 32'h2);
      check("rr_instr1", 32'(LCD_instruction), 32'h001);
      check("clr_pos",   32'(Cursor_pos_o), 32'd0);
      check("clr_line",  32'(Cursor_line_o), 32'd0);

      // Sixteen data writes from requester 0
      acks0 = ack_cycles;
      for (int i = 0; i < 15; i++) do_req(0, 9'h141, a);
      check("data15_pos",  32'(Cursor_pos_o), 32'd15);
      check("data15_line", 32'(Cursor_line_o), 32'd0);
      iss0 = issued.size();
      do_req(0, 9'h141, a);
      check("data16_ack", 32'(a), 32'h1);
      check("data16_pos", 32'(Cursor_pos_o), 32'd0);
`ifdef LCD_AUTO_WRAP_EN
      check("wrap_issued", 32'(issued.size() - iss0), 32'd2);
      check("wrap_instr",  32'(LCD_instruction), 32'h0C0);
      check("wrap_line",   32'(Cursor_line_o), 32'd1);
`else
      check("nowrap_issued", 32'(issued.size() - iss0), 32'd1);
      check("nowrap_instr",  32'(LCD_instruction), 32'h141);
      check("nowrap_line",   32'(Cursor_line_o), 32'd0);
`endif
      check("data_ack_cycles", 32'(ack_cycles - acks0), 32'd16);

      // Reset while a data write is in S_WAIT
      do_req(0, 9'h0C5, a);
      check("pre_rst_pos",  32'(Cursor_pos_o), 32'd5);
      check("pre_rst_line", 32'(Cursor_line_o), 32'd1);
      bus.Instr_i[0] = 9'h141;
      bus.Req_i[0]   = 1'b1;
      n = 0;
      while (!LCD_start && n < 50) begin
         @(negedge Clock_50);
         n++;
      end
      check("mid_start_seen", 32'(LCD_start), 32'd1);
      repeat (3) @(negedge Clock_50);
      Resetn = 1'b0;
      #1;
      check("mid_rst_start", 32'(LCD_start), 32'd0);
      check("mid_rst_instr", 32'(LCD_instruction), 32'd0);
      check("mid_rst_ack",   32'(bus.Ack_o), 32'd0);
      check("mid_rst_ready", 32'(bus.Ready_o), 32'd0);
      check("mid_rst_pos",   32'(Cursor_pos_o), 32'd0);
      check("mid_rst_line",  32'(Cursor_line_o), 32'd0);
      bus.Req_i[0] = 1'b0;
      @(negedge Clock_50);
      issued.delete();
      Resetn = 1'b1;
      wait_ready("reinit_ready");
      check_init("reinit");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
